lock_btn_cond: RTL and testbench
================================

Name: lock_btn_cond

Overview:
Button-conditioning stage that sits directly upstream of lock_top. It takes raw, asynchronous, bouncy btn_0/btn_1 pad inputs and delivers clean single-cycle press pulses on btn_0/btn_1 for the lock FSM. Per channel it synchronizes, debounces and detects rising edges, and it rejects overlapping presses so that one digit is entered per press.

Parameters:
DB_CYCLES, 16, consecutive cycles a synchronized input must differ from the debounced level before that level flips (legal range 1..65535).
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
clk  input  1  system clock; all logic on the rising edge
btn_reset  input  1  synchronous, active-high reset
btn_0_raw  input  1  raw "0" button, asynchronous, may bounce
btn_1_raw  input  1  raw "1" button, asynchronous, may bounce
btn_0  output  1  single-cycle pulse, one per accepted "0" press (to lock_top.btn_0)
btn_1  output  1  single-cycle pulse, one per accepted "1" press (to lock_top.btn_1)
btn_0_lvl  output  1  debounced level of button 0
btn_1_lvl  output  1  debounced level of button 1
btn_conflict  output  1  single-cycle pulse when a press is rejected for overlap

Behaviour:
- Reset (btn_reset=1 at a clock edge):
  - Clears sync flops, counters, debounced levels, armed flags and all outputs to 0.
  - Reset dominates every other event in the same cycle.
- Synchronizer, per channel: 2-flop chain raw -> s1 -> s2. No logic on s1.
- Debounce, per channel:
  - If s2 == lvl: cnt <= 0.
  - Otherwise cnt <= cnt+1. When cnt == DB_CYCLES-1 and s2 != lvl: lvl <= s2 and cnt <= 0.
  - Any return of s2 to lvl before the count completes restarts it from 0, so glitches shorter than DB_CYCLES cycles are filtered.
- Arming, per channel:
  - armed is cleared on reset and set at the first edge where lvl == 0 after reset.
  - A button held through reset therefore produces no pulse until it has been released.
- Edge detect: rise_x = lvl_x transitions 0->1 in this cycle while armed_x == 1.
- Overlap rule, registered outputs:
  - rise_0 and rise_1 in the same cycle: no btn pulse; btn_conflict=1.
  - rise_x while the other channel's lvl == 1: no pulse for x; btn_conflict=1.
  - Otherwise rise_x -> btn_x=1 for exactly one cycle.
- Latency: raw held high from before edge k with no bounce gives lvl=1 after edge k+1+DB_CYCLES, and btn_x is high for the cycle after edge k+2+DB_CYCLES.
- Release: lvl falls after DB_CYCLES stable-low cycles. No pulse on release.
- Holding a button: exactly one pulse however long it is held.
- btn_0 and btn_1 are never high in the same cycle.
- btn_conflict is never high together with either btn pulse.
- Counter never wraps: it is bounded by DB_CYCLES-1.

Decomposition:
- Shared package lock_pkg holds DB_CYCLES_DEFAULT and the CNT_W derivation (clog2 helper), shared with lock_top's bench.
- One sub-module, lock_debounce_ch: synchronizer, counter, lvl, armed and rise output. It is instantiated twice.
- The top handles the overlap rule and output registers.

Test Plan:
All scenarios use DB_CYCLES=4 and a 10 ns clock.
1. Reset for 1 cycle, then btn_1_raw high for 10 cycles -> exactly one btn_1 pulse, 1 cycle wide, 6 cycles after the first sampling edge. btn_1_lvl=1 until release plus 4 cycles.
2. btn_0_raw toggles every cycle for 12 cycles, then stays low -> no btn_0 pulse, btn_0_lvl stays 0, btn_conflict stays 0.
3. btn_0_raw high with a 2-cycle low glitch at cycle 3, then high for 10 cycles -> a single btn_0 pulse, delayed by the restart (counts from the glitch end).
4. btn_0_raw and btn_1_raw rise on the same edge and are held 10 cycles -> btn_conflict pulses once; btn_0 and btn_1 stay 0.
5. btn_1 held, then btn_0 pressed while btn_1_lvl=1 -> btn_1 pulses once, btn_0 is suppressed, one btn_conflict pulse.
6. btn_1_raw held high across btn_reset -> no pulse while held. After release for 4+ cycles and a re-press, exactly one btn_1 pulse.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared constants for the lock front-end and its benches.
package lock_pkg;

  // Debounce length used when nothing else is requested.
  localparam int DB_CYCLES_DEFAULT = 16;

  // Ceiling log2 for elaboration-time sizing (clog2(1) == 0).
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Smallest counter width whose range strictly exceeds db_cycles.
  function automatic int cnt_w_for(input int db_cycles);
    return clog2(db_cycles + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_w_for(DB_CYCLES_DEFAULT);

endpackage

// File: rtl/lock_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter, debounced
// level, arming flag and rising-edge detect of the debounced level.
module lock_debounce_ch
  import lock_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic i_srst,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_v1;
  logic             r_v2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lvl;
  logic             r_lvl_d;
  logic             r_armed;

  // Synchronizer chain plus a matching valid chain that marks when r_s2
  // holds a real post-reset sample rather than its cleared value.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_v1 <= 1'b1;
      r_v2 <= r_v1;
    end
  end

  // Debounce: level flips only after DB_CYCLES consecutive differing samples;
  // any agreement restarts the count, so the counter never exceeds CNT_LAST.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_cnt <= '0;
      r_lvl <= 1'b0;
    end else if (r_s2 == r_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_lvl <= r_s2;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Arm once the channel is seen idle (debounced low and a genuine low
  // sample), so a button held through reset must be released before it
  // can produce a press.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_armed <= 1'b0;
      r_lvl_d <= 1'b0;
    end else begin
      r_lvl_d <= r_lvl;
      if (r_v2 && !r_s2 && !r_lvl) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_lvl & ~r_lvl_d & r_armed;

endmodule

// File: rtl/lock_btn_cond.sv
// Button conditioning for the lock: two debounced channels feeding an
// overlap filter that emits registered single-cycle press / conflict pulses.
module lock_btn_cond
  import lock_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic btn_reset,
  input  logic btn_0_raw,
  input  logic btn_1_raw,
  output logic btn_0,
  output logic btn_1,
  output logic btn_0_lvl,
  output logic btn_1_lvl,
  output logic btn_conflict
);

  logic [1:0] w_raw;
  logic [1:0] w_lvl;
  logic [1:0] w_rise;
  logic       w_btn_0;
  logic       w_btn_1;
  logic       w_conflict;

  logic       r_btn_0;
  logic       r_btn_1;
  logic       r_conflict;

  assign w_raw = {btn_1_raw, btn_0_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      lock_debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_ch (
        .clk    (clk),
        .i_srst (btn_reset),
        .i_raw  (w_raw[gi]),
        .o_lvl  (w_lvl[gi]),
        .o_rise (w_rise[gi])
      );
    end
  endgenerate

  // Overlap filter: a rise is accepted only while the other button is up.
  // A rise implies its own level is high, so a simultaneous double rise
  // falls into the conflict terms as well.
  always_comb begin
    w_btn_0    = w_rise[0] & ~w_lvl[1];
    w_btn_1    = w_rise[1] & ~w_lvl[0];
    w_conflict = (w_rise[0] & w_lvl[1]) | (w_rise[1] & w_lvl[0]);
  end

  // Output pulse registers.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      r_btn_0    <= 1'b0;
      r_btn_1    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_btn_0    <= w_btn_0;
      r_btn_1    <= w_btn_1;
      r_conflict <= w_conflict;
    end
  end

  assign btn_0        = r_btn_0;
  assign btn_1        = r_btn_1;
  assign btn_conflict = r_conflict;
  assign btn_0_lvl    = w_lvl[0];
  assign btn_1_lvl    = w_lvl[1];

endmodule

// File: tb/tb_lock_btn_cond.sv
// Directed bench for lock_btn_cond with DB_CYCLES=4 and a 10 ns clock.
module tb_lock_btn_cond;

  localparam int DB = 4;
  localparam int CW = lock_pkg::cnt_w_for(DB);

  logic clk;
  logic btn_reset;
  logic btn_0_raw;
  logic btn_1_raw;
  logic btn_0;
  logic btn_1;
  logic btn_0_lvl;
  logic btn_1_lvl;
  logic btn_conflict;

  int errors;
  int checks;
  int edges;
  int n0, n1, nc;
  int f0, f1, fc;
  int seen0, seen1;
  int viol;

  lock_btn_cond #(
    .DB_CYCLES (DB),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .btn_reset    (btn_reset),
    .btn_0_raw    (btn_0_raw),
    .btn_1_raw    (btn_1_raw),
    .btn_0        (btn_0),
    .btn_1        (btn_1),
    .btn_0_lvl    (btn_0_lvl),
    .btn_1_lvl    (btn_1_lvl),
    .btn_conflict (btn_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_stats();
    edges = 0;
    n0 = 0; n1 = 0; nc = 0;
    f0 = -1; f1 = -1; fc = -1;
    seen0 = 0; seen1 = 0;
  endtask

  // One clock edge; outputs sampled 1 ns later and folded into the stats.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (btn_0 === 1'b1) begin n0++; if (f0 < 0) f0 = edges; end
      if (btn_1 === 1'b1) begin n1++; if (f1 < 0) f1 = edges; end
      if (btn_conflict === 1'b1) begin nc++; if (fc < 0) fc = edges; end
      if (btn_0_lvl === 1'b1) seen0 = 1;
      if (btn_1_lvl === 1'b1) seen1 = 1;
      if (btn_0 && btn_1) viol++;
      if (btn_conflict && (btn_0 || btn_1)) viol++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    viol = 0;
    btn_reset = 1'b1;
    btn_0_raw = 1'b0;
    btn_1_raw = 1'b0;
    clear_stats();

    // Reset state.
    tick();
    chk("rst_btn0", int'(btn_0), 0);
    chk("rst_btn1", int'(btn_1), 0);
    chk("rst_lvl0", int'(btn_0_lvl), 0);
    chk("rst_lvl1", int'(btn_1_lvl), 0);
    chk("rst_conflict", int'(btn_conflict), 0);
    btn_reset = 1'b0;
    tick(5);

    // 1: clean btn_1 press, latency and release.
    clear_stats();
    btn_1_raw = 1'b1;
    tick(5);
    chk("s1_lvl_pre", int'(btn_1_lvl), 0);
    tick();
    chk("s1_lvl_rise", int'(btn_1_lvl), 1);
    chk("s1_btn_early", int'(btn_1), 0);
    tick();
    chk("s1_btn_pulse", int'(btn_1), 1);
    tick();
    chk("s1_btn_after", int'(btn_1), 0);
    tick(2);
    btn_1_raw = 1'b0;
    tick(5);
    chk("s1_rel_hold", int'(btn_1_lvl), 1);
    tick();
    chk("s1_rel_fall", int'(btn_1_lvl), 0);
    tick(3);
    chk("s1_n1", n1, 1);
    chk("s1_first", f1, 7);
    chk("s1_n0", n0, 0);
    chk("s1_nc", nc, 0);

    // 2: btn_0 toggling every cycle is filtered out.
    clear_stats();
    for (int i = 0; i < 12; i++) begin
      btn_0_raw = ((i % 2) == 0);
      tick();
    end
    btn_0_raw = 1'b0;
    tick(8);
    chk("s2_n0", n0, 0);
    chk("s2_lvl0_seen", seen0, 0);
    chk("s2_nc", nc, 0);

    // 3: glitch restarts the debounce count.
    clear_stats();
    btn_0_raw = 1'b1;
    tick(3);
    btn_0_raw = 1'b0;
    tick(2);
    btn_0_raw = 1'b1;
    tick(10);
    btn_0_raw = 1'b0;
    tick(8);
    chk("s3_n0", n0, 1);
    chk("s3_first", f0, 12);
    chk("s3_nc", nc, 0);

    // 4: simultaneous presses give one conflict and no press.
    clear_stats();
    btn_0_raw = 1'b1;
    btn_1_raw = 1'b1;
    tick(10);
    btn_0_raw = 1'b0;
    btn_1_raw = 1'b0;
    tick(8);
    chk("s4_nc", nc, 1);
    chk("s4_fc", fc, 7);
    chk("s4_n0", n0, 0);
    chk("s4_n1", n1, 0);

    // 5: btn_0 pressed while btn_1 held is suppressed.
    clear_stats();
    btn_1_raw = 1'b1;
    tick(8);
    btn_0_raw = 1'b1;
    tick(10);
    btn_0_raw = 1'b0;
    tick(2);
    btn_1_raw = 1'b0;
    tick(10);
    chk("s5_n1", n1, 1);
    chk("s5_f1", f1, 7);
    chk("s5_lvl0_seen", seen0, 1);
    chk("s5_n0", n0, 0);
    chk("s5_nc", nc, 1);
    chk("s5_fc", fc, 15);

    // 6: btn_1 held across reset yields no pulse until released.
    clear_stats();
    btn_1_raw = 1'b1;
    tick(8);
    chk("s6_pre_n1", n1, 1);
    btn_reset = 1'b1;
    tick();
    chk("s6_rst_lvl1", int'(btn_1_lvl), 0);
    chk("s6_rst_btn1", int'(btn_1), 0);
    btn_reset = 1'b0;
    clear_stats();
    tick(12);
    chk("s6_held_n1", n1, 0);
    chk("s6_held_lvl1", seen1, 1);
    btn_1_raw = 1'b0;
    tick(8);
    chk("s6_rel_lvl1", int'(btn_1_lvl), 0);
    clear_stats();
    btn_1_raw = 1'b1;
    tick(10);
    btn_1_raw = 1'b0;
    tick(8);
    chk("s6_re_n1", n1, 1);
    chk("s6_re_f1", f1, 7);
    chk("s6_re_nc", nc, 0);

    // Exclusivity of the three pulse outputs over the whole run.
    chk("exclusive", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
